// File: rtl/pix_pkg.sv
// pix_pkg: shared pixel/mode widths, processing-mode encodings and arbiter state type.
package pix_pkg;
    localparam int PIX_W  = 8;
    localparam int MODE_W = 2;

    typedef enum logic [MODE_W-1:0] {
        MODE_BYPASS    = 2'b00,
        MODE_INVERT    = 2'b01,
        MODE_BRIGHTEN  = 2'b10,
        MODE_THRESHOLD = 2'b11
    } pix_mode_e;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;
endpackage

// File: rtl/pix_stream_arb_rr_pick.sv
// rr_pick: combinational round-robin picker, first set request after last_i (wrapping).
module rr_pick #(
    parameter int  N = 4,
    localparam int W = $clog2(N)
) (
    input  logic [N-1:0] req_i,
    input  logic [W-1:0] last_i,
    output logic [W-1:0] gnt_o,
    output logic         any_o
);
    logic [W-1:0] idx;

    // Walk offsets from farthest to nearest so the nearest match is written last.
    always_comb begin
        gnt_o = '0;
        idx   = '0;
        for (int i = N; i >= 1; i--) begin
            idx = W'((int'(last_i) + i) % N);
            if (req_i[idx]) gnt_o = idx;
        end
    end

    assign any_o = |req_i;
endmodule

// File: rtl/pix_stream_arb.sv
// pix_stream_arb: round-robin burst arbiter muxing NUM_REQ pixel streams onto one processing port.
// Define PIX_ARB_STATS_EN to add saturating per-requester beat counters.
module pix_stream_arb
    import pix_pkg::*;
#(
    parameter int  NUM_REQ   = 4,
    parameter int  BURST_LEN = 16,
    localparam int IW        = $clog2(NUM_REQ),
    localparam int BW        = $clog2(BURST_LEN + 1)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      arb_en,
    input  logic [NUM_REQ*PIX_W-1:0]  req_data,
    input  logic [NUM_REQ*MODE_W-1:0] req_mode,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [PIX_W-1:0]          proc_data,
    output logic [MODE_W-1:0]         proc_mode,
    output logic                      proc_valid,
    input  logic                      proc_ready,
    output logic [IW-1:0]             grant_id,
    output logic                      busy,
    input  logic [IW-1:0]             stats_sel,
    output logic [15:0]               stats_cnt
);
    arb_state_e    state_q;
    logic [IW-1:0] owner_q, last_q, pick;
    logic [BW-1:0] beat_q;
    logic          any, beat;

    rr_pick #(.N(NUM_REQ)) u_pick (
        .req_i  (req_valid),
        .last_i (last_q),
        .gnt_o  (pick),
        .any_o  (any)
    );

    assign busy       = state_q == GRANT;
    assign grant_id   = owner_q;
    assign proc_valid = busy & req_valid[owner_q];
    assign proc_data  = busy ? req_data[int'(owner_q)*PIX_W +: PIX_W] : '0;
    assign proc_mode  = busy ? req_mode[int'(owner_q)*MODE_W +: MODE_W] : '0;
    assign req_ready  = busy ? NUM_REQ'(proc_ready) << owner_q : '0;
    assign beat       = proc_valid & proc_ready;

    // owner_q is zeroed on release so grant_id reads 0 while idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            owner_q <= '0;
            last_q  <= IW'(NUM_REQ - 1);
            beat_q  <= '0;
        end else if (state_q == IDLE) begin
            if (arb_en && any) begin
                state_q <= GRANT;
                owner_q <= pick;
                beat_q  <= '0;
            end
        end else if (beat ? beat_q == BW'(BURST_LEN - 1) : !req_valid[owner_q]) begin
            state_q <= IDLE;
            last_q  <= owner_q;
            owner_q <= '0;
        end else if (beat) begin
            beat_q <= beat_q + BW'(1);
        end
    end

`ifdef PIX_ARB_STATS_EN
    logic [15:0] cnt_q [NUM_REQ];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REQ; i++) cnt_q[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++)
                if (beat && owner_q == IW'(i) && cnt_q[i] != 16'hFFFF) cnt_q[i] <= cnt_q[i] + 16'd1;
        end
    end

    assign stats_cnt = cnt_q[stats_sel];
`else
    logic unused_stats_sel;
    assign unused_stats_sel = ^stats_sel;
    assign stats_cnt        = '0;
`endif
endmodule
